pll_cen_nco: RTL

- Parametrised, fully synthesizable successor to the fixed-ratio vendor PLL wrapper.
- From one master clock, derives CHANNELS independent clock-enable streams and square-wave divided clocks. Each channel uses a fractional NCO (phase accumulator) with a programmable increment and start phase.
- Ratios are reprogrammable at runtime through a shadow-register write port with atomic commit.
- Provides a `locked` status with a settle period, so core logic can hold off until the enables are stable.

---
 rtl/pll_cen_pkg.sv | 20 ++
 rtl/pll_cen_nco_ch.sv | 42 ++++
 rtl/pll_cen_nco.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pll_cen_pkg.sv
// Shared types and constants for the clock-enable NCO block: lock FSM states,
// write-port select encodings, and an increment calculator for table generation.
package pll_cen_pkg;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam logic INC_SEL = 1'b0;
  localparam logic PH_SEL  = 1'b1;

  // Rounded increment for f_out = f_ref * inc / 2^acc_w; f_out << acc_w must fit in 64 bits.
  function automatic longint unsigned calc_inc(input longint unsigned f_out,
                                               input longint unsigned f_ref,
                                               input int unsigned     acc_w);
    return ((f_out << acc_w) + (f_ref >> 1)) / f_ref;
  endfunction

endpackage

// File: rtl/pll_cen_nco_ch.sv
// One NCO channel: phase accumulator with start-phase load, and a registered
// overflow pulse that becomes the channel's clock enable.
module pll_cen_nco_ch #(
  parameter int ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic [ACC_W-1:0] inc,
  input  logic [ACC_W-1:0] ph_load,
  input  logic             load,
  input  logic             en,
  output logic             cen_q,
  output logic             msb
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // NOTE: sum is a continuous assign, so the carry and the wrapped accumulator
  // both come from the same add and are captured together with non-blocking
  // assignments on one edge; cen_q therefore trails the overflow by one cycle.
  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cen_q <= 1'b0;
    end else if (load) begin
      acc   <= ph_load;
      cen_q <= 1'b0;
    end else begin
      if (en) begin
        acc <= sum[ACC_W-1:0];
      end
      // A disabled channel holds its phase and reports no carry.
      cen_q <= sum[ACC_W] & en;
    end
  end

  assign msb = acc[ACC_W-1];

endmodule

// File: rtl/pll_cen_nco.sv
// Multi-channel fractional clock-enable generator: shadow write port with
// atomic commit, per-channel NCOs, and a settle/lock FSM that gates the outputs.
module pll_cen_nco
  import pll_cen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024,
  parameter int CH_W        = 4
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic                wr_sel,
  input  logic [ACC_W-1:0]    wr_data,
  input  logic                commit,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] cen,
  output logic [CHANNELS-1:0] sq,
  output logic                locked
);

  localparam int               CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam int               CHW1     = CH_W + 1;
  localparam logic [CH_W:0]    CH_LIMIT = CHW1'(CHANNELS);

  logic [ACC_W-1:0] shadow_inc [CHANNELS];
  logic [ACC_W-1:0] shadow_ph  [CHANNELS];
  logic [ACC_W-1:0] active_inc [CHANNELS];
  logic [ACC_W-1:0] load_inc   [CHANNELS];
  logic [ACC_W-1:0] load_ph    [CHANNELS];

  logic                wr_hit;
  logic [CHANNELS-1:0] cen_q;
  logic [CHANNELS-1:0] acc_msb;

  lock_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  assign wr_hit = wr_en && ({1'b0, wr_ch} < CH_LIMIT);

  // load_* is the shadow contents with this cycle's write merged in; committing
  // it (not the stale shadow) lets a same-cycle write land in that commit.
  // NOTE: every output of this always_comb gets its default before the
  // conditional override, so no path leaves a value unassigned (no latch).
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      load_inc[i] = shadow_inc[i];
      load_ph[i]  = shadow_ph[i];
      if (wr_hit && (wr_ch == CH_W'(i))) begin
        if (wr_sel == PH_SEL) begin
          load_ph[i] = wr_data;
        end else begin
          load_inc[i] = wr_data;
        end
      end
    end
  end

  // NOTE: the shadow and active arrays are a handful of flops, not a RAM, so
  // they are cleared by reset like the rest of the state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_inc[i] <= '0;
        shadow_ph[i]  <= '0;
        active_inc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_inc[i] <= load_inc[i];
        shadow_ph[i]  <= load_ph[i];
        if (commit) begin
          active_inc[i] <= load_inc[i];
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pll_cen_nco_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .refclk  (refclk),
      .rst     (rst),
      .inc     (active_inc[g]),
      .ph_load (load_ph[g]),
      .load    (commit),
      .en      (ch_en[g]),
      .cen_q   (cen_q[g]),
      .msb     (acc_msb[g])
    );
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A commit always restarts the settle period, whatever state we are in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (commit) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = SETTLE;
        end
      endcase
    end
  end

  always_comb begin
    locked = (state_q == LOCKED);
    cen    = cen_q & {CHANNELS{locked}};
    sq     = acc_msb & {CHANNELS{locked}};
  end

endmodule
